// File: rtl/glitch_filter_pkg.sv
// Shared types and default constants for the glitch filter and its synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package glitch_filter_pkg;

    // Filter FSM: STABLE tracks the accepted level, PEND times a candidate change.
    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser bringing one asynchronous bit into the clk domain.
// Latency: SYNC_STAGES clk edges from d to q.
// Backpressure: none; free-running sampler.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output).
module bit_synchronizer
    import glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/glitch_filter.sv
// Debounces the hazard-network output: a level change is accepted only after
//   STABLE_CYCLES consecutive differing samples; shorter pulses are counted as glitches.
// Latency: SYNC_STAGES+STABLE_CYCLES edges from a y_in change to y_filt/edge pulse.
// Backpressure: none; outputs are registered levels/pulses.
// Ports: clk, rst_n (async active-low), y_in (raw async level), clear (sync clear of
//   glitch stats) -> y_filt, rise_pulse, fall_pulse, glitch_cnt (saturating), glitch_flag (sticky).
// Optional: GLITCH_WIDTH_CAPTURE_EN adds last_glitch_width (width in samples of the last glitch).
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             clear,
    output logic             y_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic             glitch_flag
`ifdef GLITCH_WIDTH_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] last_glitch_width
`endif
);

    localparam int                STAB_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic              s;
    state_t            state, state_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_cnt_nxt;
    logic              y_filt_nxt;
    logic              rise_nxt;
    logic              fall_nxt;
    logic              glitch_evt;

    bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE;
            stab_cnt   <= '0;
            y_filt     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            stab_cnt   <= stab_cnt_nxt;
            y_filt     <= y_filt_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        y_filt_nxt   = y_filt;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        glitch_evt   = 1'b0;
        case (state)
            STABLE: begin
                if (s != y_filt) begin
                    state_nxt    = PEND;
                    stab_cnt_nxt = STAB_W'(1);
                end
            end
            PEND: begin
                // Reverting to the accepted level is checked before the commit so
                // that a pulse one sample short of the threshold is still a glitch.
                if (s == y_filt) begin
                    state_nxt    = STABLE;
                    stab_cnt_nxt = '0;
                    glitch_evt   = 1'b1;
                end else if (stab_cnt == STAB_LAST) begin
                    state_nxt    = STABLE;
                    stab_cnt_nxt = '0;
                    y_filt_nxt   = ~y_filt;
                    rise_nxt     = ~y_filt;
                    fall_nxt     = y_filt;
                end else begin
                    stab_cnt_nxt = stab_cnt + STAB_W'(1);
                end
            end
            default: begin
                state_nxt    = STABLE;
                stab_cnt_nxt = '0;
            end
        endcase
    end

    // Glitch statistics; clear takes priority over a coincident glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt  <= '0;
            glitch_flag <= 1'b0;
        end else if (clear) begin
            glitch_cnt  <= '0;
            glitch_flag <= 1'b0;
        end else if (glitch_evt) begin
            glitch_flag <= 1'b1;
            if (glitch_cnt != '1) begin
                glitch_cnt <= glitch_cnt + CNT_W'(1);
            end
        end
    end

`ifdef GLITCH_WIDTH_CAPTURE_EN
    // stab_cnt at abort equals the number of differing samples seen; the cast
    // zero-extends or truncates to CNT_W as needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_glitch_width <= '0;
        end else if (clear) begin
            last_glitch_width <= '0;
        end else if (glitch_evt) begin
            last_glitch_width <= CNT_W'(stab_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_glitch_filter.sv
module tb_glitch_filter;

    logic       clk;
    logic       rst_n;
    logic       y_in;
    logic       clear;

    logic       y_filt, rise_pulse, fall_pulse, glitch_flag;
    logic [7:0] glitch_cnt;
    logic       y_filt2, rise_pulse2, fall_pulse2, glitch_flag2;
    logic [1:0] glitch_cnt2;
`ifdef GLITCH_WIDTH_CAPTURE_EN
    logic [7:0] last_glitch_width;
    logic [1:0] last_glitch_width2;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    glitch_filter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .y_in        (y_in),
        .clear       (clear),
        .y_filt      (y_filt),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .glitch_cnt  (glitch_cnt),
        .glitch_flag (glitch_flag)
`ifdef GLITCH_WIDTH_CAPTURE_EN
        ,
        .last_glitch_width (last_glitch_width)
`endif
    );

    glitch_filter #(
        .CNT_W (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .y_in        (y_in),
        .clear       (clear),
        .y_filt      (y_filt2),
        .rise_pulse  (rise_pulse2),
        .fall_pulse  (fall_pulse2),
        .glitch_cnt  (glitch_cnt2),
        .glitch_flag (glitch_flag2)
`ifdef GLITCH_WIDTH_CAPTURE_EN
        ,
        .last_glitch_width (last_glitch_width2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        y_in  = 1'b1;
        clear = 1'b0;
        tick(3);
        check_cnt++;
        if ({y_filt, rise_pulse, fall_pulse, glitch_flag, glitch_cnt} !== 12'h000)
            $display("FAIL reset_outputs: got y=%b r=%b f=%b flag=%b cnt=%0d want all 0",
                     y_filt, rise_pulse, fall_pulse, glitch_flag, glitch_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        tick(5);
        check_cnt++;
        if (y_filt !== 1'b0 || rise_pulse !== 1'b0)
            $display("FAIL reset_edge5: got y=%b r=%b want y=0 r=0", y_filt, rise_pulse);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b1 || fall_pulse !== 1'b0)
            $display("FAIL reset_edge6: got y=%b r=%b f=%b want y=1 r=1 f=0",
                     y_filt, rise_pulse, fall_pulse);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b0 || glitch_cnt !== 8'd0)
            $display("FAIL reset_edge7: got y=%b r=%b cnt=%0d want y=1 r=0 cnt=0",
                     y_filt, rise_pulse, glitch_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clean_edges;
        logic lvl;
        for (int i = 0; i < 3; i++) begin
            lvl  = (i == 1) ? 1'b1 : 1'b0;
            y_in = lvl;
            tick(5);
            check_cnt++;
            if (y_filt !== ~lvl || rise_pulse !== 1'b0 || fall_pulse !== 1'b0)
                $display("FAIL clean_%0d_before: got y=%b r=%b f=%b want y=%b r=0 f=0",
                         i, y_filt, rise_pulse, fall_pulse, ~lvl);
            else pass_cnt++;
            tick(1);
            check_cnt++;
            if (y_filt !== lvl || rise_pulse !== lvl || fall_pulse !== ~lvl)
                $display("FAIL clean_%0d_commit: got y=%b r=%b f=%b want y=%b r=%b f=%b",
                         i, y_filt, rise_pulse, fall_pulse, lvl, lvl, ~lvl);
            else pass_cnt++;
            tick(1);
            check_cnt++;
            if (y_filt !== lvl || rise_pulse !== 1'b0 || fall_pulse !== 1'b0)
                $display("FAIL clean_%0d_after: got y=%b r=%b f=%b want y=%b r=0 f=0",
                         i, y_filt, rise_pulse, fall_pulse, lvl);
            else pass_cnt++;
            tick(3);
        end
        check_cnt++;
        if (glitch_cnt !== 8'd0 || glitch_flag !== 1'b0)
            $display("FAIL clean_no_glitch: got cnt=%0d flag=%b want 0 0", glitch_cnt, glitch_flag);
        else pass_cnt++;
    endtask

    task automatic test_hazard_pulses;
        int bad;
        for (int w = 1; w <= 3; w++) begin
            bad  = 0;
            y_in = 1'b1;
            for (int k = 0; k < w; k++) begin
                tick(1);
                if (y_filt !== 1'b0 || rise_pulse !== 1'b0) bad++;
            end
            y_in = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                if (y_filt !== 1'b0 || rise_pulse !== 1'b0) bad++;
            end
            check_cnt++;
            if (bad != 0)
                $display("FAIL hazard_w%0d_level: got %0d cycles with y_filt/rise high want 0", w, bad);
            else pass_cnt++;
            check_cnt++;
            if (glitch_cnt !== 8'(w))
                $display("FAIL hazard_w%0d_cnt: got %0d want %0d", w, glitch_cnt, w);
            else pass_cnt++;
`ifdef GLITCH_WIDTH_CAPTURE_EN
            check_cnt++;
            if (last_glitch_width !== 8'(w))
                $display("FAIL hazard_w%0d_width: got %0d want %0d", w, last_glitch_width, w);
            else pass_cnt++;
`endif
        end
        check_cnt++;
        if (glitch_flag !== 1'b1 || glitch_cnt2 !== 2'd3)
            $display("FAIL hazard_flag: got flag=%b cnt2=%0d want 1 3", glitch_flag, glitch_cnt2);
        else pass_cnt++;
    endtask

    task automatic test_boundary_width;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_cnt++;
        if (glitch_cnt !== 8'd0 || glitch_flag !== 1'b0)
            $display("FAIL boundary_clear: got cnt=%0d flag=%b want 0 0", glitch_cnt, glitch_flag);
        else pass_cnt++;
        y_in = 1'b1;
        tick(4);
        y_in = 1'b0;
        tick(1);
        check_cnt++;
        if (y_filt !== 1'b0)
            $display("FAIL boundary_edge5: got y=%b want 0", y_filt);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (y_filt !== 1'b1 || rise_pulse !== 1'b1)
            $display("FAIL boundary_accept: got y=%b r=%b want 1 1", y_filt, rise_pulse);
        else pass_cnt++;
        tick(3);
        check_cnt++;
        if (y_filt !== 1'b1 || fall_pulse !== 1'b0)
            $display("FAIL boundary_hold: got y=%b f=%b want 1 0", y_filt, fall_pulse);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (y_filt !== 1'b0 || fall_pulse !== 1'b1 || rise_pulse !== 1'b0)
            $display("FAIL boundary_return: got y=%b f=%b r=%b want 0 1 0",
                     y_filt, fall_pulse, rise_pulse);
        else pass_cnt++;
        tick(2);
        check_cnt++;
        if (glitch_cnt !== 8'd0)
            $display("FAIL boundary_cnt: got %0d want 0", glitch_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation_clear;
        for (int g = 0; g < 5; g++) begin
            y_in = 1'b1;
            tick(1);
            y_in = 1'b0;
            tick(6);
            check_cnt++;
            if (glitch_cnt2 !== 2'((g + 1 > 3) ? 3 : g + 1))
                $display("FAIL sat_g%0d_cnt2: got %0d want %0d", g, glitch_cnt2,
                         (g + 1 > 3) ? 3 : g + 1);
            else pass_cnt++;
        end
        check_cnt++;
        if (glitch_cnt !== 8'd5 || glitch_flag2 !== 1'b1)
            $display("FAIL sat_wide_cnt: got cnt=%0d flag2=%b want 5 1", glitch_cnt, glitch_flag2);
        else pass_cnt++;
        // Sixth glitch aborts on the 4th edge after y_in rises; clear lands on that edge.
        y_in = 1'b1;
        tick(1);
        y_in = 1'b0;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_cnt++;
        if (glitch_cnt2 !== 2'd0 || glitch_flag2 !== 1'b0 || glitch_cnt !== 8'd0 || glitch_flag !== 1'b0)
            $display("FAIL sat_clear_wins: got cnt2=%0d flag2=%b cnt=%0d flag=%b want all 0",
                     glitch_cnt2, glitch_flag2, glitch_cnt, glitch_flag);
        else pass_cnt++;
`ifdef GLITCH_WIDTH_CAPTURE_EN
        check_cnt++;
        if (last_glitch_width !== 8'd0)
            $display("FAIL sat_clear_width: got %0d want 0", last_glitch_width);
        else pass_cnt++;
`endif
        tick(4);
        check_cnt++;
        if (glitch_cnt2 !== 2'd0 || glitch_flag2 !== 1'b0)
            $display("FAIL sat_glitch_lost: got cnt2=%0d flag2=%b want 0 0", glitch_cnt2, glitch_flag2);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pend;
        int bad;
        bad  = 0;
        y_in = 1'b1;
        tick(3);
        rst_n = 1'b0;
        y_in  = 1'b0;
        #1;
        check_cnt++;
        if ({y_filt, rise_pulse, fall_pulse, glitch_flag, glitch_cnt} !== 12'h000)
            $display("FAIL midpend_in_reset: got y=%b r=%b f=%b flag=%b cnt=%0d want all 0",
                     y_filt, rise_pulse, fall_pulse, glitch_flag, glitch_cnt);
        else pass_cnt++;
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (y_filt !== 1'b0 || rise_pulse !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad != 0)
            $display("FAIL midpend_level: got %0d cycles with y_filt/rise high want 0", bad);
        else pass_cnt++;
        check_cnt++;
        if (glitch_cnt !== 8'd0 || glitch_flag !== 1'b0)
            $display("FAIL midpend_cnt: got cnt=%0d flag=%b want 0 0", glitch_cnt, glitch_flag);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_edges();
        test_hazard_pulses();
        test_boundary_width();
        test_saturation_clear();
        test_reset_mid_pend();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
